// File: rtl/rf_wport_arbiter_if.sv
// Regfile write-port bus: WB and MDU requesters, ID scoreboard query, regfile write side.
interface rf_wport_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        pend1;
    logic        pend2;
    logic        stall_req;
    logic        init_done;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport slave (
        input  wb_we, wb_waddr, wb_wdata,
        input  mdu_valid, mdu_waddr, mdu_wdata,
        input  raddr1, raddr2,
        output mdu_ready, pend1, pend2, stall_req, init_done,
        output rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output wb_we, wb_waddr, wb_wdata,
        output mdu_valid, mdu_waddr, mdu_wdata,
        output raddr1, raddr2,
        input  mdu_ready, pend1, pend2, stall_req, init_done,
        input  rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: WB has priority, MDU results wait in a 1-entry hold buffer.
// Optional post-reset scrub of r1..r31 is enabled by defining RF_SCRUB_EN.
module rf_wport_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               resetn,
    rf_wport_arbiter_if.slave bus
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);

`ifdef RF_SCRUB_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t     state_q, state_d;
    logic [4:0] scrub_cnt_q, scrub_cnt_d;
`endif

    logic        hold_valid_q, hold_valid_d;
    logic [4:0]  hold_waddr_q, hold_waddr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;

    logic        run;
    logic        wb_wr;
    logic        hold_drain;
    logic        hold_kill;
    logic        mdu_ready_c;
    logic        rf_we_c;
    logic [4:0]  rf_waddr_c;
    logic [31:0] rf_wdata_c;
    logic        pend1_c, pend2_c, stall_c, init_done_c;

    always_comb begin
`ifdef RF_SCRUB_EN
        run         = (state_q == ST_RUN);
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
`else
        run         = 1'b1;
`endif
        hold_valid_d = hold_valid_q;
        hold_waddr_d = hold_waddr_q;
        hold_wdata_d = hold_wdata_q;
        starve_cnt_d = starve_cnt_q;
        mdu_ready_c  = 1'b0;
        rf_we_c      = 1'b0;
        rf_waddr_c   = '0;
        rf_wdata_c   = '0;
        pend1_c      = 1'b0;
        pend2_c      = 1'b0;
        stall_c      = 1'b0;
        init_done_c  = 1'b0;

        wb_wr      = bus.wb_we && (bus.wb_waddr != '0);
        hold_drain = hold_valid_q && !wb_wr;
        hold_kill  = hold_valid_q && wb_wr && (bus.wb_waddr == hold_waddr_q);

        if (run) begin
            init_done_c = 1'b1;
            stall_c     = (starve_cnt_q >= STARVE_LIM);
            // A killed entry frees the slot just like a drained one.
            mdu_ready_c = !hold_valid_q || hold_drain || hold_kill;
            pend1_c     = hold_valid_q && (bus.raddr1 == hold_waddr_q) && (bus.raddr1 != '0);
            pend2_c     = hold_valid_q && (bus.raddr2 == hold_waddr_q) && (bus.raddr2 != '0);

            if (wb_wr) begin
                rf_we_c    = 1'b1;
                rf_waddr_c = bus.wb_waddr;
                rf_wdata_c = bus.wb_wdata;
            end else if (hold_valid_q) begin
                rf_we_c    = 1'b1;
                rf_waddr_c = hold_waddr_q;
                rf_wdata_c = hold_wdata_q;
            end

            if (hold_drain || hold_kill) begin
                hold_valid_d = 1'b0;
                starve_cnt_d = '0;
            end else if (hold_valid_q) begin
                if (starve_cnt_q != 3'd7) starve_cnt_d = starve_cnt_q + 3'd1;
            end

            if (bus.mdu_valid && mdu_ready_c && (bus.mdu_waddr != '0)) begin
                hold_valid_d = 1'b1;
                hold_waddr_d = bus.mdu_waddr;
                hold_wdata_d = bus.mdu_wdata;
                starve_cnt_d = '0;
            end
        end
`ifdef RF_SCRUB_EN
        else begin
            rf_we_c     = 1'b1;
            rf_waddr_c  = scrub_cnt_q;
            stall_c     = 1'b1;
            scrub_cnt_d = scrub_cnt_q + 5'd1;
            if (scrub_cnt_q == 5'd31) state_d = ST_RUN;
        end
`endif
    end

    // Write strobe and handshake are held off while reset is asserted.
    assign bus.rf_we     = rf_we_c && resetn;
    assign bus.mdu_ready = mdu_ready_c && resetn;
    assign bus.rf_waddr  = rf_waddr_c;
    assign bus.rf_wdata  = rf_wdata_c;
    assign bus.pend1     = pend1_c;
    assign bus.pend2     = pend2_c;
    assign bus.stall_req = stall_c;
    assign bus.init_done = init_done_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
`ifdef RF_SCRUB_EN
            state_q     <= ST_INIT;
            scrub_cnt_q <= 5'd1;
`endif
            hold_valid_q <= 1'b0;
            hold_waddr_q <= '0;
            hold_wdata_q <= '0;
            starve_cnt_q <= '0;
        end else begin
`ifdef RF_SCRUB_EN
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
`endif
            hold_valid_q <= hold_valid_d;
            hold_waddr_q <= hold_waddr_d;
            hold_wdata_q <= hold_wdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
